// File: rtl/mac_pipe.sv
`timescale 1ns/1ps
// mac_pipe: three-stage pipelined unsigned multiply-add / multiply-accumulate.
//   result = a*b + c    (acc_en = 0)
//   result = a*b + acc  (acc_en = 1), where acc is the last emitted result.
// Valid/ready on both sides. A single pipeline enable advances every stage
// together, so a stalled sink freezes the whole pipe, bubbles included.
// Overflow either clamps to all-ones (SAT=1) or wraps (SAT=0); ovf flags it.
module mac_pipe #(
    parameter int A_W   = 4,
    parameter int B_W   = 4,
    parameter int C_W   = 8,
    parameter int OUT_W = 8,
    parameter bit SAT   = 1'b1
) (
    input  logic             clk,
    input  logic             rst,        // synchronous, active-low
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [A_W-1:0]   a,
    input  logic [B_W-1:0]   b,
    input  logic [C_W-1:0]   c,
    input  logic             acc_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] result,
    output logic             ovf
);

    // Full-precision product width, and a sum width one bit wider than the
    // widest addend so the addition itself can never lose a carry.
    localparam int PROD_W = A_W + B_W;
    localparam int MAX1_W = (PROD_W > C_W)   ? PROD_W : C_W;
    localparam int MAX2_W = (MAX1_W > OUT_W) ? MAX1_W : OUT_W;
    localparam int SUM_W  = MAX2_W + 1;

    // ------------------------------------------------------------------
    // Pipeline enable
    // ------------------------------------------------------------------
    // The output register is free when empty or being drained this cycle;
    // only then may anything in the pipe move.
    logic en;

    assign en       = ~out_valid | out_ready;
    assign in_ready = en;

    // ------------------------------------------------------------------
    // Stage 1: operand capture
    // ------------------------------------------------------------------
    logic             v1;
    logic [A_W-1:0]   a1;
    logic [B_W-1:0]   b1;
    logic [C_W-1:0]   c1;
    logic             acc_en1;

    // Register the incoming beat; in_valid=0 at an enabled edge loads a bubble.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // stage samples the previous-cycle value of the stage before it.
        if (!rst) begin
            v1      <= 1'b0;
            a1      <= '0;
            b1      <= '0;
            c1      <= '0;
            acc_en1 <= 1'b0;
        end else if (en) begin
            v1      <= in_valid;
            a1      <= a;
            b1      <= b;
            c1      <= c;
            acc_en1 <= acc_en;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: multiply
    // ------------------------------------------------------------------
    logic              v2;
    logic [PROD_W-1:0] prod2;
    logic [C_W-1:0]    c2;
    logic              acc_en2;

    // Form the full-width product and carry the addend controls alongside it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            v2      <= 1'b0;
            prod2   <= '0;
            c2      <= '0;
            acc_en2 <= 1'b0;
        end else if (en) begin
            v2      <= v1;
            prod2   <= PROD_W'(a1) * PROD_W'(b1);
            c2      <= c1;
            acc_en2 <= acc_en1;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: add, overflow detect, saturate/wrap
    // ------------------------------------------------------------------
    logic [OUT_W-1:0] acc;
    logic [SUM_W-1:0] sum_comb;
    logic             ovf_comb;
    logic [OUT_W-1:0] result_comb;

    // Add the selected operand at full width and decide the final value.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path
        // through the block can leave a value unassigned and infer a latch.
        sum_comb    = '0;
        ovf_comb    = 1'b0;
        result_comb = '0;

        sum_comb    = SUM_W'(prod2) + (acc_en2 ? SUM_W'(acc) : SUM_W'(c2));
        ovf_comb    = |sum_comb[SUM_W-1:OUT_W];
        result_comb = (ovf_comb && SAT) ? {OUT_W{1'b1}} : sum_comb[OUT_W-1:0];
    end

    // Publish a result only for a real beat; bubbles clear out_valid but leave
    // result, ovf and the accumulator untouched. acc follows the emitted
    // result, so a back-to-back accumulate sees the previous beat directly.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            ovf       <= 1'b0;
            acc       <= '0;
        end else if (en) begin
            out_valid <= v2;
            if (v2) begin
                result <= result_comb;
                ovf    <= ovf_comb;
                acc    <= result_comb;
            end
        end
    end

endmodule

// File: tb/tb_mac_pipe.sv
`timescale 1ns/1ps
// Self-checking bench for mac_pipe. The driver pushes a hand-computed
// expected {result, ovf} whenever a beat is accepted; an independent monitor
// pops and compares on every output handshake.
module tb_mac_pipe;

    localparam bit SAT = 1'b1;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] c;
    logic       acc_en;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       ovf;

    typedef struct {
        logic [7:0] res;
        logic       ovf;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    mac_pipe #(
        .A_W(4), .B_W(4), .C_W(8), .OUT_W(8), .SAT(SAT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .c        (c),
        .acc_en   (acc_en),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Present one beat, wait (bounded) until it is accepted, then record the
    // expected response. Returns 1 ns after the accepting edge.
    task automatic send(input logic [3:0] ta, input logic [3:0] tb, input logic [7:0] tc,
                        input logic tacc, input logic [7:0] eres, input logic eovf);
        bit   taken = 0;
        exp_t e;
        a = ta; b = tb; c = tc; acc_en = tacc; in_valid = 1'b1;
        for (int n = 0; n < 50 && !taken; n++) begin
            @(negedge clk);
            taken = in_ready;
            @(posedge clk);
            #1;
        end
        if (!taken) begin
            errors++;
            checks++;
            $display("FAIL send_timeout: beat a=%0d b=%0d never accepted", ta, tb);
        end else begin
            e.res = eres;
            e.ovf = eovf;
            exp_q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Wait (bounded) until every expected response has been observed.
    task automatic drain();
        for (int n = 0; n < 50 && exp_q.size() != 0; n++) @(posedge clk);
        #1;
        check("drain_queue_empty", exp_q.size(), 0);
    endtask

    // Monitor: compare every output handshake against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL unexpected_output: got result=%0d, expected no output", result);
                end else begin
                    e = exp_q.pop_front();
                    check("result", result, e.res);
                    check("ovf", ovf, e.ovf);
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] held;

        rst = 1'b0; in_valid = 1'b0; a = '0; b = '0; c = '0; acc_en = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_ovf", ovf, 0);
        check("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // 1. Latency: accepted at edge 0, visible after edge 2, gone after edge 3
        a = 4'd3; b = 4'd5; c = 8'd10; acc_en = 1'b0; in_valid = 1'b1;
        exp_q.push_back('{res: 8'd25, ovf: 1'b0});
        @(posedge clk); #1;            // edge 0
        in_valid = 1'b0;
        @(posedge clk); #1;            // edge 1
        check("lat_valid_e1", out_valid, 0);
        @(posedge clk); #1;            // edge 2
        check("lat_valid_e2", out_valid, 1);
        check("lat_result_e2", result, 25);
        @(posedge clk); #1;            // edge 3
        check("lat_valid_e3", out_valid, 0);

        // 2. Accumulate chain, back-to-back
        send(4'd15, 4'd15, 8'd0, 1'b0, 8'd225, 1'b0);
        send(4'd1,  4'd1,  8'd0, 1'b1, 8'd226, 1'b0);
        send(4'd2,  4'd3,  8'd0, 1'b1, 8'd232, 1'b0);
        idle(1);
        drain();

        // 3. Overflow, then a small beat clears ovf
        send(4'd15, 4'd15, 8'd100, 1'b0, SAT ? 8'd255 : 8'd69, 1'b1);
        send(4'd1,  4'd1,  8'd0,   1'b0, 8'd1, 1'b0);
        idle(1);
        drain();

        // 4. Backpressure: 5 beats, sink stalls for 4 cycles mid-stream
        fork
            begin
                for (int i = 0; i < 5; i++)
                    send(4'(i + 1), 4'd2, 8'(i), 1'b0, 8'(2 * (i + 1) + i), 1'b0);
                idle(1);
            end
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b0;
                @(negedge clk);
                held = result;
                for (int i = 0; i < 4; i++) begin
                    check("stall_in_ready", in_ready, 0);
                    check("stall_out_valid", out_valid, 1);
                    check("stall_result_hold", result, held);
                    if (i < 3) @(negedge clk);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // 5. Bubbles with accumulation: acc = 14 from the last beat above
        send(4'd1, 4'd1, 8'd0, 1'b1, 8'd15, 1'b0);
        idle(1);
        send(4'd1, 4'd2, 8'd0, 1'b1, 8'd17, 1'b0);
        idle(1);
        send(4'd3, 4'd1, 8'd0, 1'b1, 8'd20, 1'b0);
        idle(2);
        drain();

        // 6. Reset mid-stream: two beats inside, a third presented at the reset edge
        a = 4'd7; b = 4'd7; c = 8'd1; acc_en = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        a = 4'd6;
        @(posedge clk); #1;
        a = 4'd5;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_result", result, 0);
        check("midrst_ovf", ovf, 0);
        idle(5);
        check("midrst_no_stale", out_valid, 0);
        send(4'd2, 4'd2, 8'd99, 1'b1, 8'd4, 1'b0);
        idle(1);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
